// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller: phase encoding and
// lamp patterns. Lamp vectors are ordered {R,Y,G} and are one-hot.
package tlc_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    PED_WALK    = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_B   = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer: up-counter cleared on every phase entry. done flags the
// last cycle of a phase (count == duration-1). The counter saturates so
// an open-ended hold never wraps back into the minimum-time window.
module tlc_phase_timer
  import tlc_pkg::*;
#(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [TIMER_W-1:0] duration,
  output logic [TIMER_W-1:0] count,
  output logic               done
);

  logic [TIMER_W-1:0] r_count;

  // Count cycles spent in the current phase; restart at 0 on phase entry.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (r_count != {TIMER_W{1'b1}}) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign done  = (r_count == (duration - 1'b1));

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road intersection phase controller with one pedestrian crossing.
// Optional feature macro: TLC_SIDE_SENSOR_EN adds the side_car input and
// makes main green demand-driven (held until a car or pedestrian waits).
module traffic_light_fsm
  import tlc_pkg::*;
#(
  parameter int GREEN_CYCLES      = 20,
  parameter int MIN_GREEN_CYCLES  = 5,
  parameter int SIDE_GREEN_CYCLES = 10,
  parameter int YELLOW_CYCLES     = 3,
  parameter int ALLRED_CYCLES     = 2,
  parameter int WALK_CYCLES       = 8,
  parameter int TIMER_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_clean,
`ifdef TLC_SIDE_SENSOR_EN
  input  logic       side_car,
`endif
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       req_pending
);

  localparam logic [TIMER_W-1:0] DUR_GREEN  = TIMER_W'(GREEN_CYCLES);
  localparam logic [TIMER_W-1:0] DUR_SIDE   = TIMER_W'(SIDE_GREEN_CYCLES);
  localparam logic [TIMER_W-1:0] DUR_YELLOW = TIMER_W'(YELLOW_CYCLES);
  localparam logic [TIMER_W-1:0] DUR_ALLRED = TIMER_W'(ALLRED_CYCLES);
  localparam logic [TIMER_W-1:0] DUR_WALK   = TIMER_W'(WALK_CYCLES);
  localparam logic [TIMER_W-1:0] MIN_LAST   = TIMER_W'(MIN_GREEN_CYCLES - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_ped_prev;
  logic               r_req_pending;
  logic               w_ped_edge;
  logic               w_enter_walk;
  logic               w_phase_change;
  logic [TIMER_W-1:0] w_duration;
  logic [TIMER_W-1:0] w_count;
  logic               w_done;
  logic               w_min_met;

  assign w_ped_edge     = ped_clean & ~r_ped_prev;
  assign w_phase_change = (w_next_state != r_state);
  assign w_enter_walk   = (w_next_state == PED_WALK) && (r_state != PED_WALK);
  assign w_min_met      = (w_count >= MIN_LAST);

`ifdef TLC_SIDE_SENSOR_EN
  logic r_car_pending;
  logic w_car_demand;
  logic w_enter_side;

  // The raw sensor counts as demand immediately so a car arriving during a
  // long hold ends the green on the very next edge.
  assign w_car_demand = r_car_pending | side_car;
  assign w_enter_side = (w_next_state == SIDE_GREEN) && (r_state != SIDE_GREEN);

  // Remember a waiting side-road vehicle until its green phase starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_car_pending <= 1'b0;
    end else if (w_enter_side) begin
      r_car_pending <= 1'b0;
    end else if (side_car) begin
      r_car_pending <= 1'b1;
    end
  end
`endif

  tlc_phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_phase_change),
    .duration (w_duration),
    .count    (w_count),
    .done     (w_done)
  );

  // Phase state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MAIN_GREEN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch one request per button rising edge; a request being served
  // (entering or inside the walk phase) swallows any edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ped_prev    <= 1'b0;
      r_req_pending <= 1'b0;
    end else begin
      r_ped_prev <= ped_clean;
      if (w_enter_walk) begin
        r_req_pending <= 1'b0;
      end else if (w_ped_edge && (r_state != PED_WALK)) begin
        r_req_pending <= 1'b1;
      end
    end
  end

  // Select the running phase's duration and decide the next phase.
  always_comb begin
    w_next_state = r_state;
    w_duration   = DUR_GREEN;
    case (r_state)
      MAIN_GREEN: begin
        w_duration = DUR_GREEN;
`ifdef TLC_SIDE_SENSOR_EN
        if ((r_req_pending || w_car_demand) && w_min_met) w_next_state = MAIN_YELLOW;
`else
        if (w_done || (r_req_pending && w_min_met)) w_next_state = MAIN_YELLOW;
`endif
      end
      MAIN_YELLOW: begin
        w_duration = DUR_YELLOW;
        if (w_done) w_next_state = ALL_RED_A;
      end
      ALL_RED_A: begin
        w_duration = DUR_ALLRED;
        if (w_done) w_next_state = r_req_pending ? PED_WALK : SIDE_GREEN;
      end
      PED_WALK: begin
        w_duration = DUR_WALK;
`ifdef TLC_SIDE_SENSOR_EN
        if (w_done) w_next_state = w_car_demand ? SIDE_GREEN : ALL_RED_B;
`else
        if (w_done) w_next_state = SIDE_GREEN;
`endif
      end
      SIDE_GREEN: begin
        w_duration = DUR_SIDE;
        if (w_done) w_next_state = SIDE_YELLOW;
      end
      SIDE_YELLOW: begin
        w_duration = DUR_YELLOW;
        if (w_done) w_next_state = ALL_RED_B;
      end
      ALL_RED_B: begin
        w_duration = DUR_ALLRED;
        if (w_done) w_next_state = MAIN_GREEN;
      end
      default: begin
        w_next_state = MAIN_GREEN;
      end
    endcase
  end

  // Lamps decode directly from the state register, so they switch on the
  // same edge as the state.
  always_comb begin
    main_light = LAMP_R;
    side_light = LAMP_R;
    walk       = 1'b0;
    case (r_state)
      MAIN_GREEN:  main_light = LAMP_G;
      MAIN_YELLOW: main_light = LAMP_Y;
      PED_WALK:    walk       = 1'b1;
      SIDE_GREEN:  side_light = LAMP_G;
      SIDE_YELLOW: side_light = LAMP_Y;
      default:     ;
    endcase
  end

  assign req_pending = r_req_pending;

endmodule
